scrapcpu_bus_responder: RTL and testbench

Board-side responder for the CPU's multiplexed 8-bit external bus: it latches the 16-bit address from two latch strobes and answers read/write strobes from an internal byte memory. Reads and writes take a programmable number of wait states, which are signalled on `ready`. It sits opposite the CPU core on the uio bus, in the FPGA companion or cocotb harness, and gives the CPU a memory to fetch from and store to. A backdoor port preloads program images.

---
 rtl/scrapcpu_bus_responder.sv | 152 +++++++++++++++
 tb/tb_scrapcpu_bus_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/scrapcpu_bus_responder.sv
// Board-side responder for the CPU's multiplexed 8-bit bus: latches a 16-bit address,
// then serves read/write strobes from a byte memory after a fixed number of wait states.
module scrapcpu_bus_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        bus_in,
    input  logic              cpu_oe,
    input  logic              le_lo,
    input  logic              le_hi,
    input  logic              rd,
    input  logic              wr,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              ready,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RWAIT  = 3'd1;
    localparam logic [2:0] RDRIVE = 3'd2;
    localparam logic [2:0] WWAIT  = 3'd3;
    localparam logic [2:0] WDONE  = 3'd4;

    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    logic [7:0]  mem [DEPTH];

    logic [2:0]  state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [15:0] addr_q,    addr_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        bus_oe_q,  bus_oe_d;
    logic        ready_q,   ready_d;
    logic        err_q,     err_d;
    logic        mem_we;

    logic [ADDR_W-1:0] idx;
    assign idx = addr_q[ADDR_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        bus_out_d = bus_out_q;
        err_d     = err_q | (bus_oe_q & cpu_oe);
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (le_lo) addr_d[7:0]  = bus_in;
                if (le_hi) addr_d[15:8] = bus_in;
                if (rd && wr) begin
                    err_d = 1'b1;
                end else if (rd) begin
                    if (NO_WAIT) begin
                        bus_out_d = mem[idx];
                        state_d   = RDRIVE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = RWAIT;
                    end
                end else if (wr) begin
                    if (NO_WAIT) begin
                        mem_we  = 1'b1;
                        state_d = WDONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WWAIT;
                    end
                end
            end
            RWAIT: begin
                if (!rd) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    bus_out_d = mem[idx];
                    state_d   = RDRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RDRIVE: begin
                if (!rd) begin
                    addr_d  = addr_q + 16'd1;
                    state_d = IDLE;
                end
            end
            WWAIT: begin
                if (!wr) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    mem_we  = 1'b1;
                    state_d = WDONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WDONE: begin
                if (!wr) begin
                    addr_d  = addr_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so they are registered yet line up with it
        bus_oe_d = (state_d == RDRIVE);
        ready_d  = (state_d == RDRIVE) || (state_d == WDONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 16'd0;
            bus_out_q <= 8'h00;
            bus_oe_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    // Memory survives reset; the bus write comes second so it wins a same-index collision
    always_ff @(posedge clk) begin
        if (ld_en)           mem[ld_addr] <= ld_data;
        if (mem_we && !rst)  mem[idx]     <= bus_in;
    end

    assign bus_out = bus_out_q;
    assign bus_oe  = bus_oe_q;
    assign ready   = ready_q;
    assign err     = err_q;

endmodule

// File: tb/tb_scrapcpu_bus_responder.sv
// Directed bench for scrapcpu_bus_responder: expected read data is queued when a read
// is issued and popped when the responder drives the bus.
module tb_scrapcpu_bus_responder;

    localparam int ADDR_W      = 8;
    localparam int WAIT_STATES = 1;
    localparam int MAX_WAIT    = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        bus_in;
    logic              cpu_oe;
    logic              le_lo;
    logic              le_hi;
    logic              rd;
    logic              wr;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic [7:0]        bus_out;
    logic              bus_oe;
    logic              ready;
    logic              err;

    int tests    = 0;
    int failures = 0;
    logic [7:0] sb [$];

    scrapcpu_bus_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .cpu_oe(cpu_oe),
        .le_lo(le_lo), .le_hi(le_hi), .rd(rd), .wr(wr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .bus_out(bus_out), .bus_oe(bus_oe), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic lo, input logic hi, input logic [7:0] val);
        rd = r; wr = w; le_lo = lo; le_hi = hi; bus_in = val;
        step();
        le_lo = 1'b0; le_hi = 1'b0;
    endtask

    task automatic latch(input logic [15:0] a);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, a[7:0]);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, a[15:8]);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] exp);
        int lat;
        logic [7:0] want;
        sb.push_back(exp);
        rd = 1'b1; lat = 0;
        do begin
            step();
            lat++;
        end while (!bus_oe && lat < MAX_WAIT);
        want = sb.pop_front();
        checkOutput({tag, "_bus_oe"}, 16'(bus_oe), 16'd1);
        checkOutput({tag, "_latency"}, 16'(lat), 16'(WAIT_STATES + 1));
        checkOutput({tag, "_ready"}, 16'(ready), 16'd1);
        checkOutput({tag, "_data"}, 16'(bus_out), 16'(want));
        rd = 1'b0;
        step();
        checkOutput({tag, "_release"}, {14'd0, bus_oe, ready}, 16'd0);
    endtask

    task automatic do_write(input string tag, input logic [7:0] data);
        int lat;
        wr = 1'b1; bus_in = data; lat = 0;
        do begin
            step();
            lat++;
        end while (!ready && lat < MAX_WAIT);
        checkOutput({tag, "_ready"}, 16'(ready), 16'd1);
        checkOutput({tag, "_latency"}, 16'(lat), 16'(WAIT_STATES + 1));
        checkOutput({tag, "_no_oe"}, 16'(bus_oe), 16'd0);
        wr = 1'b0;
        step();
        checkOutput({tag, "_release"}, 16'(ready), 16'd0);
    endtask

    initial begin
        rst = 1'b1; bus_in = 8'h00; cpu_oe = 1'b0; le_lo = 1'b0; le_hi = 1'b0;
        rd = 1'b0; wr = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = 8'h00;
        step();
        step();
        checkOutput("reset_outputs", {5'd0, bus_oe, ready, err, bus_out}, 16'd0);
        rst = 1'b0;
        step();

        preload(8'h12, 8'hA5);
        preload(8'h13, 8'h5A);
        preload(8'h00, 8'h77);
        preload(8'h01, 8'h11);
        preload(8'hFF, 8'h99);
        preload(8'h41, 8'h41);
        preload(8'h50, 8'h50);
        checkOutput("preload_no_oe", 16'(bus_oe), 16'd0);

        // Read 0x0012, then read again without relatching to prove addr moved to 0x0013
        latch(16'h0012);
        do_read("rd12", 8'hA5);
        do_read("rd13", 8'h5A);

        // Abort in RWAIT: no drive, no increment
        latch(16'h0012);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rd_abort_no_oe", {14'd0, bus_oe, ready}, 16'd0);
        step();
        do_read("rd_after_abort", 8'hA5);

        latch(16'h0040);
        do_write("wr40", 8'h3C);
        latch(16'h0040);
        do_read("rd40", 8'h3C);

        // Abort a write in WWAIT: memory must keep the preloaded value
        latch(16'h0041);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hEE);
        checkOutput("wr_abort_no_ready", 16'(ready), 16'd0);
        step();
        latch(16'h0041);
        do_read("rd41", 8'h41);

        // Both latch strobes together load 0xFFFF; reads wrap to 0x0000 then 0x0001
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
        do_read("rdFFFF", 8'h99);
        do_read("rd0000", 8'h77);
        do_read("rd0001", 8'h11);

        latch(16'h0050);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hDD);
        checkOutput("rdwr_err", {14'd0, err, bus_oe}, 16'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rdwr_no_ready", {14'd0, bus_oe, ready}, 16'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("err_cleared", 16'(err), 16'd0);
        latch(16'h0050);
        do_read("rd50", 8'h50);

        // Contention while driving sets a sticky error
        latch(16'h0012);
        rd = 1'b1;
        step();
        step();
        checkOutput("cont_pre_err", {14'd0, bus_oe, err}, 16'd2);
        cpu_oe = 1'b1;
        step();
        checkOutput("cont_err", 16'(err), 16'd1);
        cpu_oe = 1'b0; rd = 1'b0;
        step();
        step();
        step();
        checkOutput("cont_err_sticky", 16'(err), 16'd1);

        // Reset during RDRIVE drops the drive and zeroes the address
        rst = 1'b1;
        step();
        rst = 1'b0;
        latch(16'h0012);
        rd = 1'b1;
        step();
        step();
        checkOutput("pre_rst_drive", 16'(bus_oe), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; rd = 1'b0;
        checkOutput("rst_mid_read", {13'd0, bus_oe, ready, err}, 16'd0);
        step();
        do_read("rd_after_rst", 8'h77);

        // Backdoor and bus write hit the same index on the same edge: bus data wins
        latch(16'h0060);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hB6);
        ld_en = 1'b1; ld_addr = 8'h60; ld_data = 8'h0F;
        step();
        ld_en = 1'b0;
        checkOutput("collide_ready", 16'(ready), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        latch(16'h0060);
        do_read("rd60", 8'hB6);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
